// File: rtl/fir_tdm_scheduler.sv
// fir_tdm_scheduler
//   Shares one multi-channel Avalon-ST FIR interpolator between NCH audio
//   channels. A parallel input frame is issued to the FIR sink one channel per
//   cycle, framed by sop/eop, with at least GAP_CYC idle cycles after each eop.
//   The FIR source stream is collected back into a parallel output frame.
//
// Ports
//   AMCLK_i       audio master clock, all logic on the rising edge
//   nARST         synchronous active-low reset
//   in_data_i     input frame, channel k at [k*DIN_W +: DIN_W]
//   in_valid_i    one-cycle input frame strobe
//   sink_*_o      FIR sink beat (data/valid/sop/eop), registered
//   src_*_i       FIR source beat (data/valid/sop/eop)
//   out_data_o    interpolated frame, channel k at [k*DOUT_W +: DOUT_W]
//   out_valid_o   one-cycle strobe, out_data_o held until the next strobe
//   ovf_o         sticky: an input frame was dropped
//   frame_err_o   sticky: source framing violation
//   clr_i         clears both sticky flags (a simultaneous set wins)
module fir_tdm_scheduler #(
  parameter int NCH     = 2,
  parameter int DIN_W   = 17,
  parameter int DOUT_W  = 24,
  parameter int GAP_CYC = 1
) (
  input  logic                    AMCLK_i,
  input  logic                    nARST,
  input  logic [NCH*DIN_W-1:0]    in_data_i,
  input  logic                    in_valid_i,
  output logic [DIN_W-1:0]        sink_data_o,
  output logic                    sink_valid_o,
  output logic                    sink_sop_o,
  output logic                    sink_eop_o,
  input  logic [DOUT_W-1:0]       src_data_i,
  input  logic                    src_valid_i,
  input  logic                    src_sop_i,
  input  logic                    src_eop_i,
  output logic [NCH*DOUT_W-1:0]   out_data_o,
  output logic                    out_valid_o,
  output logic                    ovf_o,
  output logic                    frame_err_o,
  input  logic                    clr_i
);

  localparam int              KW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int              CW     = $clog2(NCH + 1);
  localparam logic [KW-1:0]   K_LAST = KW'(NCH - 1);
  localparam logic [CW-1:0]   C_FULL = CW'(NCH);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);
  localparam logic [3:0]      GAP_LD = 4'(GAP_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [KW-1:0]          k_r, k_nx_s;
  logic [3:0]             gap_r, gap_nx_s;
  logic [NCH*DIN_W-1:0]   issue_r, issue_nx_s;
  logic [NCH*DIN_W-1:0]   pend_r, pend_nx_s;
  logic                   pend_vld_r, pend_vld_nx_s;
  logic [DIN_W-1:0]       sink_data_nx_s;
  logic                   sink_valid_nx_s, sink_sop_nx_s, sink_eop_nx_s;
  logic                   try_s;
  logic                   ovf_set_s;

  logic [CW-1:0]          cnt_r, cnt_nx_s, cnt_after_s, wr_idx_s;
  logic [NCH*DOUT_W-1:0]  shadow_r, shadow_nx_s;
  logic                   wr_en_s, err_s, good_s;

  // Pick channel k of a sink-width frame.
  function automatic logic [DIN_W-1:0] ch_sel(input logic [NCH*DIN_W-1:0] frame,
                                              input logic [KW-1:0] k);
    ch_sel = frame[int'(k)*DIN_W +: DIN_W];
  endfunction

  // Scheduler next state, input capture and next sink beat.
  always_comb begin
    state_nx_s      = state_r;
    k_nx_s          = k_r;
    gap_nx_s        = gap_r;
    issue_nx_s      = issue_r;
    pend_nx_s       = pend_r;
    pend_vld_nx_s   = pend_vld_r;
    sink_data_nx_s  = '0;
    sink_valid_nx_s = 1'b0;
    sink_sop_nx_s   = 1'b0;
    sink_eop_nx_s   = 1'b0;
    ovf_set_s       = 1'b0;

    // try_s: this cycle applies the IDLE entry test (a new frame may launch)
    case (state_r)
      ST_IDLE:  try_s = 1'b1;
      ST_ISSUE: try_s = (k_r == K_LAST) && (GAP_CYC == 0);
      ST_GAP:   try_s = (gap_r == 4'd1);
      default:  try_s = 1'b1;
    endcase

    if (try_s && (pend_vld_r || in_valid_i)) begin
      // Pending frame goes first; a coincident strobe refills the freed slot.
      state_nx_s      = ST_ISSUE;
      k_nx_s          = '0;
      issue_nx_s      = pend_vld_r ? pend_r : in_data_i;
      pend_vld_nx_s   = pend_vld_r && in_valid_i;
      pend_nx_s       = (pend_vld_r && in_valid_i) ? in_data_i : pend_r;
      sink_valid_nx_s = 1'b1;
      sink_data_nx_s  = issue_nx_s[DIN_W-1:0];
      sink_sop_nx_s   = 1'b1;
      sink_eop_nx_s   = (NCH == 1);
    end else if (try_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      // Busy issuing or waiting out the gap: a strobe can only be parked.
      if (in_valid_i && pend_vld_r) begin
        ovf_set_s = 1'b1;
      end else if (in_valid_i) begin
        pend_vld_nx_s = 1'b1;
        pend_nx_s     = in_data_i;
      end else begin
        pend_vld_nx_s = pend_vld_r;
      end

      if (state_r == ST_ISSUE && k_r == K_LAST) begin
        state_nx_s = ST_GAP;
        gap_nx_s   = GAP_LD;
      end else if (state_r == ST_ISSUE) begin
        k_nx_s          = k_r + 1'b1;
        sink_valid_nx_s = 1'b1;
        sink_data_nx_s  = ch_sel(issue_r, k_nx_s);
        sink_eop_nx_s   = (k_nx_s == K_LAST);
      end else begin
        gap_nx_s = gap_r - 4'd1;
      end
    end
  end

  // Scheduler state and registered sink outputs.
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      state_r      <= ST_IDLE;
      k_r          <= '0;
      gap_r        <= 4'd0;
      issue_r      <= '0;
      pend_r       <= '0;
      pend_vld_r   <= 1'b0;
      sink_data_o  <= '0;
      sink_valid_o <= 1'b0;
      sink_sop_o   <= 1'b0;
      sink_eop_o   <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      k_r          <= k_nx_s;
      gap_r        <= gap_nx_s;
      issue_r      <= issue_nx_s;
      pend_r       <= pend_nx_s;
      pend_vld_r   <= pend_vld_nx_s;
      sink_data_o  <= sink_data_nx_s;
      sink_valid_o <= sink_valid_nx_s;
      sink_sop_o   <= sink_sop_nx_s;
      sink_eop_o   <= sink_eop_nx_s;
      ovf_o        <= ovf_set_s ? 1'b1 : (clr_i ? 1'b0 : ovf_o);
    end
  end

  // Source beat classification and shadow-buffer update.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_idx_s    = '0;
    cnt_after_s = cnt_r;
    cnt_nx_s    = cnt_r;
    err_s       = 1'b0;
    good_s      = 1'b0;

    if (src_valid_i) begin
      if (src_sop_i) begin
        wr_en_s     = 1'b1;
        wr_idx_s    = '0;
        cnt_after_s = C_ONE;
      end else if (cnt_r == '0 || cnt_r >= C_FULL) begin
        // beat outside a frame, or more beats than channels
        err_s = 1'b1;
      end else begin
        wr_en_s     = 1'b1;
        wr_idx_s    = cnt_r;
        cnt_after_s = cnt_r + 1'b1;
      end

      if (err_s) begin
        cnt_nx_s = '0;
      end else if (src_eop_i && cnt_after_s == C_FULL) begin
        cnt_nx_s = '0;
        good_s   = 1'b1;
      end else if (src_eop_i) begin
        cnt_nx_s = '0;
        err_s    = 1'b1;
      end else begin
        cnt_nx_s = cnt_after_s;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end

    for (int c = 0; c < NCH; c++) begin
      shadow_nx_s[c*DOUT_W +: DOUT_W] = (wr_en_s && wr_idx_s == CW'(c)) ?
                                        src_data_i : shadow_r[c*DOUT_W +: DOUT_W];
    end
  end

  // Collection counter, shadow buffer and registered output frame.
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      cnt_r       <= '0;
      shadow_r    <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      cnt_r       <= cnt_nx_s;
      shadow_r    <= shadow_nx_s;
      out_data_o  <= good_s ? shadow_nx_s : out_data_o;
      out_valid_o <= good_s;
      frame_err_o <= err_s ? 1'b1 : (clr_i ? 1'b0 : frame_err_o);
    end
  end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// tb_fir_tdm_scheduler
//   Directed bench for fir_tdm_scheduler. Three instances:
//     u_dut_a  NCH=2, GAP_CYC=1 : basic frame, loopback, overflow, framing error
//     u_dut_z  NCH=2, GAP_CYC=0 : back-to-back frames
//     u_dut_r  NCH=4, GAP_CYC=1 : reset in the middle of a frame
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_fir_tdm_scheduler;

  logic        amclk;
  logic        narst;
  logic        r_narst;

  // instance A
  logic [33:0] a_in_data;
  logic        a_in_valid;
  logic [16:0] a_sink_data;
  logic        a_sink_valid, a_sink_sop, a_sink_eop;
  logic [23:0] src_data;
  logic        src_valid, src_sop, src_eop;
  logic [47:0] a_out_data;
  logic        a_out_valid, a_ovf, a_ferr, a_clr;

  // instance Z
  logic [33:0] z_in_data;
  logic        z_in_valid;
  logic [16:0] z_sink_data;
  logic        z_sink_valid, z_sink_sop, z_sink_eop;
  logic [47:0] z_out_data;
  logic        z_out_valid, z_ovf, z_ferr;

  // instance R
  logic [67:0] r_in_data;
  logic        r_in_valid;
  logic [16:0] r_sink_data;
  logic        r_sink_valid, r_sink_sop, r_sink_eop;
  logic [95:0] r_out_data;
  logic        r_out_valid, r_ovf, r_ferr;

  logic        zero_bit;
  logic [23:0] zero_src;

  int n_vec;
  int n_err;

  fir_tdm_scheduler #(.NCH(2), .DIN_W(17), .DOUT_W(24), .GAP_CYC(1)) u_dut_a (
    .AMCLK_i(amclk), .nARST(narst),
    .in_data_i(a_in_data), .in_valid_i(a_in_valid),
    .sink_data_o(a_sink_data), .sink_valid_o(a_sink_valid),
    .sink_sop_o(a_sink_sop), .sink_eop_o(a_sink_eop),
    .src_data_i(src_data), .src_valid_i(src_valid),
    .src_sop_i(src_sop), .src_eop_i(src_eop),
    .out_data_o(a_out_data), .out_valid_o(a_out_valid),
    .ovf_o(a_ovf), .frame_err_o(a_ferr), .clr_i(a_clr)
  );

  fir_tdm_scheduler #(.NCH(2), .DIN_W(17), .DOUT_W(24), .GAP_CYC(0)) u_dut_z (
    .AMCLK_i(amclk), .nARST(narst),
    .in_data_i(z_in_data), .in_valid_i(z_in_valid),
    .sink_data_o(z_sink_data), .sink_valid_o(z_sink_valid),
    .sink_sop_o(z_sink_sop), .sink_eop_o(z_sink_eop),
    .src_data_i(zero_src), .src_valid_i(zero_bit),
    .src_sop_i(zero_bit), .src_eop_i(zero_bit),
    .out_data_o(z_out_data), .out_valid_o(z_out_valid),
    .ovf_o(z_ovf), .frame_err_o(z_ferr), .clr_i(zero_bit)
  );

  fir_tdm_scheduler #(.NCH(4), .DIN_W(17), .DOUT_W(24), .GAP_CYC(1)) u_dut_r (
    .AMCLK_i(amclk), .nARST(r_narst),
    .in_data_i(r_in_data), .in_valid_i(r_in_valid),
    .sink_data_o(r_sink_data), .sink_valid_o(r_sink_valid),
    .sink_sop_o(r_sink_sop), .sink_eop_o(r_sink_eop),
    .src_data_i(zero_src), .src_valid_i(zero_bit),
    .src_sop_i(zero_bit), .src_eop_i(zero_bit),
    .out_data_o(r_out_data), .out_valid_o(r_out_valid),
    .ovf_o(r_ovf), .frame_err_o(r_ferr), .clr_i(zero_bit)
  );

  initial amclk = 1'b0;
  always #5 amclk = ~amclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge amclk);
    #1;
  endtask

  task automatic src_beat(input logic [23:0] d, input logic s, input logic e);
    src_valid = 1'b1;
    src_data  = d;
    src_sop   = s;
    src_eop   = e;
  endtask

  task automatic src_idle();
    src_valid = 1'b0;
    src_data  = 24'h0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    zero_bit = 1'b0;
    zero_src = 24'h0;
    narst = 1'b0;
    r_narst = 1'b0;
    a_in_data = 34'h0;  a_in_valid = 1'b0;  a_clr = 1'b0;
    z_in_data = 34'h0;  z_in_valid = 1'b0;
    r_in_data = 68'h0;  r_in_valid = 1'b0;
    src_idle();

    // ---------------- reset state
    tick();
    tick();
    check_eq("rst_sink_valid", {63'd0, a_sink_valid}, 64'd0);
    check_eq("rst_sink_data",  {47'd0, a_sink_data}, 64'd0);
    check_eq("rst_out_data",   {16'd0, a_out_data}, 64'd0);
    check_eq("rst_out_valid",  {63'd0, a_out_valid}, 64'd0);
    check_eq("rst_ovf",        {63'd0, a_ovf}, 64'd0);
    check_eq("rst_ferr",       {63'd0, a_ferr}, 64'd0);
    narst = 1'b1;
    r_narst = 1'b1;
    tick();

    // ---------------- basic frame: ch0=0x00123, ch1=0x1FFFF
    a_in_data  = {17'h1FFFF, 17'h00123};
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check_eq("basic_b0_valid", {63'd0, a_sink_valid}, 64'd1);
    check_eq("basic_b0_data",  {47'd0, a_sink_data}, 64'h00123);
    check_eq("basic_b0_sop",   {63'd0, a_sink_sop}, 64'd1);
    check_eq("basic_b0_eop",   {63'd0, a_sink_eop}, 64'd0);
    tick();
    check_eq("basic_b1_valid", {63'd0, a_sink_valid}, 64'd1);
    check_eq("basic_b1_data",  {47'd0, a_sink_data}, 64'h1FFFF);
    check_eq("basic_b1_sop",   {63'd0, a_sink_sop}, 64'd0);
    check_eq("basic_b1_eop",   {63'd0, a_sink_eop}, 64'd1);
    tick();
    check_eq("basic_gap_valid", {63'd0, a_sink_valid}, 64'd0);

    // ---------------- loopback: sign-extended echo four cycles after the sink beats
    tick();
    tick();
    src_beat(24'h000123, 1'b1, 1'b0);
    tick();
    src_beat(24'hFFFFFF, 1'b0, 1'b1);
    check_eq("lb_no_early_valid", {63'd0, a_out_valid}, 64'd0);
    tick();
    src_idle();
    check_eq("lb_out_valid", {63'd0, a_out_valid}, 64'd1);
    check_eq("lb_out_data",  {16'd0, a_out_data}, 64'hFFFFFF000123);
    tick();
    check_eq("lb_valid_pulse", {63'd0, a_out_valid}, 64'd0);
    check_eq("lb_data_hold",   {16'd0, a_out_data}, 64'hFFFFFF000123);

    // ---------------- overflow: three strobes on consecutive cycles
    a_in_data  = {17'h00002, 17'h00001};
    a_in_valid = 1'b1;
    tick();
    check_eq("ovf_f1_b0", {47'd0, a_sink_data}, 64'h00001);
    a_in_data = {17'h00004, 17'h00003};
    tick();
    check_eq("ovf_f1_b1", {47'd0, a_sink_data}, 64'h00002);
    check_eq("ovf_f1_eop", {63'd0, a_sink_eop}, 64'd1);
    a_in_data = {17'h00006, 17'h00005};
    tick();
    a_in_valid = 1'b0;
    check_eq("ovf_gap_valid", {63'd0, a_sink_valid}, 64'd0);
    check_eq("ovf_flag_set",  {63'd0, a_ovf}, 64'd1);
    tick();
    check_eq("ovf_f2_b0_valid", {63'd0, a_sink_valid}, 64'd1);
    check_eq("ovf_f2_b0_sop",   {63'd0, a_sink_sop}, 64'd1);
    check_eq("ovf_f2_b0_data",  {47'd0, a_sink_data}, 64'h00003);
    tick();
    check_eq("ovf_f2_b1_data",  {47'd0, a_sink_data}, 64'h00004);
    check_eq("ovf_f2_b1_eop",   {63'd0, a_sink_eop}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ovf_f3_dropped", {63'd0, a_sink_valid}, 64'd0);
    end
    check_eq("ovf_sticky", {63'd0, a_ovf}, 64'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check_eq("ovf_cleared", {63'd0, a_ovf}, 64'd0);

    // ---------------- framing error: eop after a single beat
    src_beat(24'hABCDEF, 1'b1, 1'b1);
    tick();
    src_idle();
    check_eq("ferr_set",      {63'd0, a_ferr}, 64'd1);
    check_eq("ferr_no_valid", {63'd0, a_out_valid}, 64'd0);
    check_eq("ferr_data_hold", {16'd0, a_out_data}, 64'hFFFFFF000123);
    src_beat(24'h111111, 1'b1, 1'b0);
    tick();
    src_beat(24'h222222, 1'b0, 1'b1);
    tick();
    src_idle();
    check_eq("ferr_next_valid", {63'd0, a_out_valid}, 64'd1);
    check_eq("ferr_next_data",  {16'd0, a_out_data}, 64'h222222111111);
    check_eq("ferr_sticky",     {63'd0, a_ferr}, 64'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check_eq("ferr_cleared", {63'd0, a_ferr}, 64'd0);
    // stray non-sop beat with clear in the same cycle: set wins
    src_beat(24'h333333, 1'b0, 1'b0);
    a_clr = 1'b1;
    tick();
    src_idle();
    a_clr = 1'b0;
    check_eq("ferr_set_wins",   {63'd0, a_ferr}, 64'd1);
    check_eq("ferr_stray_hold", {16'd0, a_out_data}, 64'h222222111111);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check_eq("ferr_cleared2", {63'd0, a_ferr}, 64'd0);

    // ---------------- zero gap: second strobe in the last ISSUE cycle
    z_in_data  = {17'h0000B, 17'h0000A};
    z_in_valid = 1'b1;
    tick();
    z_in_valid = 1'b0;
    check_eq("zg_b1_valid", {63'd0, z_sink_valid}, 64'd1);
    check_eq("zg_b1_sop",   {63'd0, z_sink_sop}, 64'd1);
    check_eq("zg_b1_data",  {47'd0, z_sink_data}, 64'h0000A);
    tick();
    z_in_data  = {17'h0000D, 17'h0000C};
    z_in_valid = 1'b1;
    check_eq("zg_b2_valid", {63'd0, z_sink_valid}, 64'd1);
    check_eq("zg_b2_eop",   {63'd0, z_sink_eop}, 64'd1);
    check_eq("zg_b2_data",  {47'd0, z_sink_data}, 64'h0000B);
    tick();
    z_in_valid = 1'b0;
    check_eq("zg_b3_valid", {63'd0, z_sink_valid}, 64'd1);
    check_eq("zg_b3_sop",   {63'd0, z_sink_sop}, 64'd1);
    check_eq("zg_b3_data",  {47'd0, z_sink_data}, 64'h0000C);
    tick();
    check_eq("zg_b4_valid", {63'd0, z_sink_valid}, 64'd1);
    check_eq("zg_b4_eop",   {63'd0, z_sink_eop}, 64'd1);
    check_eq("zg_b4_data",  {47'd0, z_sink_data}, 64'h0000D);
    tick();
    check_eq("zg_end_valid", {63'd0, z_sink_valid}, 64'd0);
    check_eq("zg_no_ovf",    {63'd0, z_ovf}, 64'd0);

    // ---------------- reset mid-frame, NCH=4, with a frame parked in pending
    r_in_data  = {17'h00044, 17'h00033, 17'h00022, 17'h00011};
    r_in_valid = 1'b1;
    tick();
    check_eq("rm_b0_data", {47'd0, r_sink_data}, 64'h00011);
    check_eq("rm_b0_sop",  {63'd0, r_sink_sop}, 64'd1);
    r_in_data = {17'h00088, 17'h00077, 17'h00066, 17'h00055};
    tick();
    r_in_valid = 1'b0;
    check_eq("rm_b1_data", {47'd0, r_sink_data}, 64'h00022);
    check_eq("rm_b1_eop",  {63'd0, r_sink_eop}, 64'd0);
    r_narst = 1'b0;
    tick();
    check_eq("rm_valid_zero", {63'd0, r_sink_valid}, 64'd0);
    check_eq("rm_data_zero",  {47'd0, r_sink_data}, 64'd0);
    check_eq("rm_sop_zero",   {63'd0, r_sink_sop}, 64'd0);
    check_eq("rm_eop_zero",   {63'd0, r_sink_eop}, 64'd0);
    check_eq("rm_out_lo",     r_out_data[63:0], 64'd0);
    check_eq("rm_out_hi",     {32'd0, r_out_data[95:64]}, 64'd0);
    check_eq("rm_outv_zero",  {63'd0, r_out_valid}, 64'd0);
    check_eq("rm_ovf_zero",   {63'd0, r_ovf}, 64'd0);
    check_eq("rm_ferr_zero",  {63'd0, r_ferr}, 64'd0);
    r_narst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("rm_idle_valid", {63'd0, r_sink_valid}, 64'd0);
      check_eq("rm_idle_eop",   {63'd0, r_sink_eop}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
